// File: rtl/fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction memory port and decode.
// Ports: master = fetch queue side (drives mem_req/mem_addr and the decode
//   head signals); slave = memory + decode side (drives mem_done/mem_rdata/
//   mem_fault and inst_take).
interface fetch_queue_if #(
    parameter int VA = 16
);
    logic          mem_req;
    logic [VA-2:0] mem_addr;
    logic          mem_done;
    logic [15:0]   mem_rdata;
    logic          mem_fault;

    logic          inst_valid;
    logic [15:0]   inst;
    logic [VA-2:0] inst_pc;
    logic          inst_fault;
    logic          inst_take;
    logic          busy;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_done,
        input  mem_rdata,
        input  mem_fault,
        output inst_valid,
        output inst,
        output inst_pc,
        output inst_fault,
        input  inst_take,
        output busy
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_done,
        output mem_rdata,
        output mem_fault,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  inst_fault,
        output inst_take,
        input  busy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words sequentially ahead of
// decode into a small circular FIFO, flushing and restarting on redirect.
// Ports: clk; reset (synchronous, active-low); i_redirect / i_redirect_pc
//   (flush, restart fetch at new halfword PC); bus (fetch_queue_if.master:
//   memory request/response and the decode head entry + inst_take, busy).
// Build option: FQ_BYPASS_EN forwards a word returning to an empty queue
//   straight to decode in the same cycle; undefined = fully registered head.
module fetch_queue #(
    parameter int VA    = 16,
    parameter int DEPTH = 4,
    localparam int PTRW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_redirect,
    input  logic [VA-2:0] i_redirect_pc,
    fetch_queue_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [PTRW:0] C_FULL = (PTRW+1)'(DEPTH);

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0]     r_data  [DEPTH];
    logic [VA-2:0]   r_pc    [DEPTH];
    logic            r_fault [DEPTH];

    logic [PTRW-1:0] r_rd_ptr;
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW:0]   r_count;
    logic [VA-2:0]   r_fetch_pc;
    logic [VA-2:0]   r_disc_addr;
    logic            r_halt;

    logic            w_empty;
    logic            w_accept;
    logic            w_bypass;
    logic            w_take;
    logic            w_write;
    logic [PTRW:0]   w_count_nxt;

    assign w_empty  = (r_count == '0);

    // A returning word is kept only in FETCH and only if no redirect
    // arrives in the same cycle; otherwise it belongs to the old stream.
    assign w_accept = (r_state == S_FETCH) && bus.mem_done && !i_redirect;

`ifdef FQ_BYPASS_EN
    assign w_bypass = w_accept && !bus.mem_fault && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A redirect flushes the queue, so a simultaneous take is meaningless.
    assign w_take  = bus.inst_take && !w_empty && !i_redirect;

    // A bypassed word consumed directly by decode never enters storage.
    assign w_write = w_accept && !(w_bypass && bus.inst_take);

    assign w_count_nxt = r_count
                       + {{PTRW{1'b0}}, w_write}
                       - {{PTRW{1'b0}}, w_take};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_redirect) begin
                    w_state_nxt = S_FETCH;
                end else if ((r_count < C_FULL) && !r_halt) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_redirect) begin
                    // Outstanding request must complete before restarting.
                    w_state_nxt = bus.mem_done ? S_FETCH : S_DISCARD;
                end else if (bus.mem_done) begin
                    if (bus.mem_fault) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_count_nxt < C_FULL) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (bus.mem_done) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_fetch_pc  <= '0;
            r_disc_addr <= '0;
            r_halt      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_redirect) begin
                r_count    <= '0;
                r_rd_ptr   <= r_wr_ptr;
                r_fetch_pc <= i_redirect_pc;
                r_halt     <= 1'b0;
                // Remember the in-flight address so the request stays
                // stable on the bus while its data is dropped.
                if ((r_state == S_FETCH) && !bus.mem_done) begin
                    r_disc_addr <= r_fetch_pc;
                end
            end else begin
                r_count <= w_count_nxt;
                if (w_write) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_take) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 1'b1;
                    if (bus.mem_fault) begin
                        r_halt <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_write) begin
            r_data[r_wr_ptr]  <= bus.mem_rdata;
            r_pc[r_wr_ptr]    <= r_fetch_pc;
            r_fault[r_wr_ptr] <= bus.mem_fault;
        end
    end

    assign bus.mem_req  = (r_state != S_IDLE);
    assign bus.mem_addr = (r_state == S_DISCARD) ? r_disc_addr : r_fetch_pc;
    assign bus.busy     = (r_state != S_IDLE);

    // Head fields are forced to zero when empty so storage needs no reset.
`ifdef FQ_BYPASS_EN
    assign bus.inst_valid = !w_empty || w_bypass;
    assign bus.inst       = !w_empty ? r_data[r_rd_ptr]
                          : (w_bypass ? bus.mem_rdata : 16'h0000);
    assign bus.inst_pc    = !w_empty ? r_pc[r_rd_ptr]
                          : (w_bypass ? r_fetch_pc : '0);
    assign bus.inst_fault = !w_empty && r_fault[r_rd_ptr];
`else
    assign bus.inst_valid = !w_empty;
    assign bus.inst       = w_empty ? 16'h0000 : r_data[r_rd_ptr];
    assign bus.inst_pc    = w_empty ? '0 : r_pc[r_rd_ptr];
    assign bus.inst_fault = !w_empty && r_fault[r_rd_ptr];
`endif

endmodule
